// File: rtl/quad_decoder.sv
// quad_decoder -- quadrature (A/B) encoder decoder with wrapping position count.
//
// Synchronises the asynchronous A/B encoder lines through 2-flop chains,
// compares the synchronised state against the previous one and classifies each
// change as up, down, hold or illegal (both bits changed). Valid steps move a
// modulo-2**WIDTH position count (+1 up, -1 down) and update the direction flag.
//
// Optional feature macro: QDEC_INDEX_EN
//   When defined, adds idx_in. A synchronised rising edge of idx_in zeroes the
//   count at the same latency as an A/B step.
//
// Parameters
//   WIDTH      position count width
//   PRIME_CYC  cycles after reset release during which nothing is decoded
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   idx_in     index channel, asynchronous (QDEC_INDEX_EN only)
//   a_in/b_in  encoder channels, asynchronous
//   clr        synchronous count clear (pulse or level)
//   err_clr    clears the sticky err flag
//   count      position count
//   dir        last valid direction, 1 = up
//   step_up    1-cycle pulse per valid up transition
//   step_dn    1-cycle pulse per valid down transition
//   err_pulse  1-cycle pulse per illegal transition
//   err        sticky illegal-transition flag
module quad_decoder #(
  parameter int WIDTH     = 4,
  parameter int PRIME_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
`ifdef QDEC_INDEX_EN
  input  logic             idx_in,
`endif
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr,
  input  logic             err_clr,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step_up,
  output logic             step_dn,
  output logic             err_pulse,
  output logic             err
);

  localparam int PW = (PRIME_CYC < 1) ? 1 : $clog2(PRIME_CYC + 1);

  logic          a_s1, a_s2, b_s1, b_s2;
  logic [1:0]    prev;
  logic [PW-1:0] prime_cnt;

  logic [1:0] cur;
  logic [1:0] pc, pp;
  logic       priming, is_up, is_dn, is_err, idx_rise;

  // Position of a Gray state along the up sequence 00->10->11->01.
  function automatic logic [1:0] gpos(input logic [1:0] ab);
    case (ab)
      2'b00:   gpos = 2'd0;
      2'b10:   gpos = 2'd1;
      2'b11:   gpos = 2'd2;
      default: gpos = 2'd3;
    endcase
  endfunction

  assign cur     = {a_s2, b_s2};
  assign pc      = gpos(cur);
  assign pp      = gpos(prev);
  assign priming = (prime_cnt != '0);
  // One step forward/back around the 4-state ring; a 2-position jump is the
  // both-bits-changed case and is reported as an error instead.
  assign is_up   = (pc == pp + 2'd1);
  assign is_dn   = (pp == pc + 2'd1);
  assign is_err  = ((cur ^ prev) == 2'b11);

`ifdef QDEC_INDEX_EN
  logic idx_s1, idx_s2, idx_prev;
  assign idx_rise = idx_s2 & ~idx_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_s1   <= 1'b0;
      idx_s2   <= 1'b0;
      idx_prev <= 1'b0;
    end else begin
      idx_s1   <= idx_in;
      idx_s2   <= idx_s1;
      // During priming the edge register is loaded with the value the sync
      // chain is about to present, so an index already high at reset release
      // is not seen as a rising edge.
      idx_prev <= priming ? idx_s1 : idx_s2;
    end
  end
`else
  assign idx_rise = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      a_s1      <= 1'b0;
      a_s2      <= 1'b0;
      b_s1      <= 1'b0;
      b_s2      <= 1'b0;
      prev      <= 2'b00;
      prime_cnt <= PW'(PRIME_CYC);
      count     <= '0;
      dir       <= 1'b1;
      step_up   <= 1'b0;
      step_dn   <= 1'b0;
      err_pulse <= 1'b0;
      err       <= 1'b0;
    end else begin
      a_s1      <= a_in;
      a_s2      <= a_s1;
      b_s1      <= b_in;
      b_s2      <= b_s1;
      step_up   <= 1'b0;
      step_dn   <= 1'b0;
      err_pulse <= 1'b0;

      if (priming) begin
        prime_cnt <= prime_cnt - PW'(1);
        // Track what s2 becomes at this edge: the sync flops start from 0
        // after reset, so tracking the stale s2 would turn inputs sitting at
        // 11 into a false 00->11 error on the first decode.
        prev      <= {a_s1, b_s1};
      end else begin
        prev      <= cur;
        step_up   <= is_up;
        step_dn   <= is_dn;
        err_pulse <= is_err;
        if (is_up) dir <= 1'b1;
        if (is_dn) dir <= 1'b0;
      end

      // clr > index > step; pulses and dir above are unaffected by a clear.
      if (clr)
        count <= '0;
      else if (!priming && idx_rise)
        count <= '0;
      else if (!priming && is_up)
        count <= count + WIDTH'(1);
      else if (!priming && is_dn)
        count <= count - WIDTH'(1);

      // A new error wins over a same-cycle clear.
      if (!priming && is_err)
        err <= 1'b1;
      else if (err_clr)
        err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
module tb_quad_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_in = 1'b0, b_in = 1'b0, clr = 1'b0, err_clr = 1'b0;
`ifdef QDEC_INDEX_EN
  logic       idx_in = 1'b0;
`endif
  logic [3:0] count;
  logic       dir, step_up, step_dn, err_pulse, err;

  int errors = 0;
  int checks = 0;

  quad_decoder #(.WIDTH(4), .PRIME_CYC(2)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef QDEC_INDEX_EN
    .idx_in    (idx_in),
`endif
    .a_in      (a_in),
    .b_in      (b_in),
    .clr       (clr),
    .err_clr   (err_clr),
    .count     (count),
    .dir       (dir),
    .step_up   (step_up),
    .step_dn   (step_dn),
    .err_pulse (err_pulse),
    .err       (err)
  );

  always #5 clk = ~clk;

  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] ab);
    a_in = ab[1];
    b_in = ab[0];
    clr = 1'b0;
    err_clr = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (4) tick();
  endtask

  // Apply an A/B state and hold it 4 cycles, counting output pulses.
  task automatic drive(input logic [1:0] ab, output int nu, output int nd,
                       output int ne, output int nm);
    nu = 0; nd = 0; ne = 0; nm = 0;
    a_in = ab[1];
    b_in = ab[0];
    repeat (4) begin
      tick();
      nu += int'(step_up);
      nd += int'(step_dn);
      ne += int'(err_pulse);
      if (int'(step_up) + int'(step_dn) + int'(err_pulse) > 1) nm++;
    end
  endtask

  task automatic test_reset();
    a_in = 1'b0; b_in = 1'b0; reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (count !== 4'd0 || dir !== 1'b1 || err !== 1'b0 ||
        step_up !== 1'b0 || step_dn !== 1'b0 || err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset: count=%0d dir=%b err=%b up=%b dn=%b ep=%b, want 0 1 0 0 0 0",
               count, dir, err, step_up, step_dn, err_pulse);
    end
  endtask

  task automatic test_prime_11();
    int nu = 0, nd = 0, ne = 0;
    a_in = 1'b1; b_in = 1'b1; reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (10) begin
      tick();
      nu += int'(step_up); nd += int'(step_dn); ne += int'(err_pulse);
    end
    checks++;
    if (ne != 0 || err !== 1'b0) begin
      errors++;
      $display("FAIL prime_err: err_pulses=%0d err=%b, want 0 0", ne, err);
    end
    checks++;
    if (count !== 4'd0 || nu != 0 || nd != 0) begin
      errors++;
      $display("FAIL prime_count: count=%0d up=%0d dn=%0d, want 0 0 0", count, nu, nd);
    end
  endtask

  task automatic test_latency();
    do_reset(2'b00);
    a_in = 1'b1;
    tick(); // s1 samples
    tick(); // s2 samples
    checks++;
    if (count !== 4'd0 || step_up !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: count=%0d up=%b, want 0 0", count, step_up);
    end
    tick();
    checks++;
    if (count !== 4'd1 || step_up !== 1'b1) begin
      errors++;
      $display("FAIL latency_land: count=%0d up=%b, want 1 1", count, step_up);
    end
    tick();
    checks++;
    if (count !== 4'd1 || step_up !== 1'b0) begin
      errors++;
      $display("FAIL latency_pulse_width: count=%0d up=%b, want 1 0", count, step_up);
    end
  endtask

  task automatic test_up_wrap();
    logic [1:0] upseq [4];
    logic [3:0] exp;
    int nu, nd, ne, nm;
    upseq[0] = 2'b10; upseq[1] = 2'b11; upseq[2] = 2'b01; upseq[3] = 2'b00;
    do_reset(2'b00);
    for (int i = 0; i < 16; i++) begin
      drive(upseq[i % 4], nu, nd, ne, nm);
      exp = 4'((i + 1) % 16);
      checks++;
      if (count !== exp || nu != 1 || nd != 0 || ne != 0 || nm != 0) begin
        errors++;
        $display("FAIL up_step[%0d]: count=%0d up=%0d dn=%0d ep=%0d multi=%0d, want count=%0d up=1",
                 i, count, nu, nd, ne, nm, exp);
      end
    end
    checks++;
    if (dir !== 1'b1) begin
      errors++;
      $display("FAIL up_dir: dir=%b, want 1", dir);
    end
  endtask

  // Continues from test_up_wrap: count 0, inputs at 00.
  task automatic test_down_wrap();
    int nu, nd, ne, nm;
    drive(2'b01, nu, nd, ne, nm);
    checks++;
    if (count !== 4'd15 || nd != 1 || nu != 0 || ne != 0 || dir !== 1'b0) begin
      errors++;
      $display("FAIL down_wrap: count=%0d dn=%0d up=%0d ep=%0d dir=%b, want 15 1 0 0 0",
               count, nd, nu, ne, dir);
    end
  endtask

  task automatic test_error();
    int nu, nd, ne, nm;
    do_reset(2'b00);
    drive(2'b10, nu, nd, ne, nm);     // count 1
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (count !== 4'd0) begin
      errors++;
      $display("FAIL clr_pulse: count=%0d, want 0", count);
    end
    drive(2'b11, nu, nd, ne, nm);     // 1
    drive(2'b01, nu, nd, ne, nm);     // 2
    drive(2'b00, nu, nd, ne, nm);     // 3
    checks++;
    if (count !== 4'd3) begin
      errors++;
      $display("FAIL err_setup: count=%0d, want 3", count);
    end
    drive(2'b11, nu, nd, ne, nm);     // illegal 00->11
    checks++;
    if (ne != 1 || err !== 1'b1 || count !== 4'd3 || nu != 0 || nd != 0 || dir !== 1'b1) begin
      errors++;
      $display("FAIL err_jump: ep=%0d err=%b count=%0d up=%0d dn=%0d dir=%b, want 1 1 3 0 0 1",
               ne, err, count, nu, nd, dir);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b0 || count !== 4'd3) begin
      errors++;
      $display("FAIL err_clr: err=%b count=%0d, want 0 3", err, count);
    end
  endtask

  task automatic test_clr_vs_step();
    int nu, nd, ne, nm;
    do_reset(2'b00);
    drive(2'b10, nu, nd, ne, nm);
    drive(2'b11, nu, nd, ne, nm);
    drive(2'b01, nu, nd, ne, nm);
    drive(2'b00, nu, nd, ne, nm);
    drive(2'b10, nu, nd, ne, nm);
    checks++;
    if (count !== 4'd5) begin
      errors++;
      $display("FAIL clr_setup: count=%0d, want 5", count);
    end
    a_in = 1'b1; b_in = 1'b1;
    tick();
    tick();
    clr = 1'b1;
    tick();                           // step lands together with clr
    checks++;
    if (count !== 4'd0 || step_up !== 1'b1 || dir !== 1'b1) begin
      errors++;
      $display("FAIL clr_step: count=%0d up=%b dir=%b, want 0 1 1", count, step_up, dir);
    end
    clr = 1'b0;
    repeat (3) tick();
    checks++;
    if (count !== 4'd0 || step_up !== 1'b0) begin
      errors++;
      $display("FAIL clr_hold: count=%0d up=%b, want 0 0", count, step_up);
    end
    drive(2'b01, nu, nd, ne, nm);
    checks++;
    if (count !== 4'd1 || nu != 1) begin
      errors++;
      $display("FAIL clr_next: count=%0d up=%0d, want 1 1", count, nu);
    end
  endtask

`ifdef QDEC_INDEX_EN
  task automatic test_index();
    logic [1:0] upseq [4];
    int nu, nd, ne, nm;
    upseq[0] = 2'b10; upseq[1] = 2'b11; upseq[2] = 2'b01; upseq[3] = 2'b00;
    idx_in = 1'b0;
    do_reset(2'b00);
    for (int i = 0; i < 7; i++) drive(upseq[i % 4], nu, nd, ne, nm);
    checks++;
    if (count !== 4'd7) begin
      errors++;
      $display("FAIL idx_setup: count=%0d, want 7", count);
    end
    idx_in = 1'b1;
    tick();
    tick();
    checks++;
    if (count !== 4'd7) begin
      errors++;
      $display("FAIL idx_early: count=%0d, want 7", count);
    end
    tick();
    checks++;
    if (count !== 4'd0) begin
      errors++;
      $display("FAIL idx_clear: count=%0d, want 0", count);
    end
    drive(2'b00, nu, nd, ne, nm);     // state 01 -> 00: up, idx still high
    repeat (4) tick();
    checks++;
    if (count !== 4'd1 || nu != 1) begin
      errors++;
      $display("FAIL idx_held: count=%0d up=%0d, want 1 1", count, nu);
    end
    idx_in = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_prime_11();
    test_latency();
    test_up_wrap();
    test_down_wrap();
    test_error();
    test_clr_vs_step();
`ifdef QDEC_INDEX_EN
    test_index();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
